imem_stream_loader: RTL and testbench
=====================================

Name: imem_stream_loader

Overview:
Synthesizable successor to the simulation-only instruction-memory file reader. Holds the processor's instruction memory and fills it from a valid/ready word stream (testbench file driver, UART or debug bridge) in place of a $fopen/$fscanf loop. Provides the fetch stage with a 1-cycle-latency, two-word read port so 32-bit (opcode + immediate) instructions fetch in one access. Asserts a hold to the pipeline until a complete image has loaded.

Parameters:
DATA_W, 16, instruction word width in bits
ADDR_W, 20, address width; DEPTH = 2**ADDR_W words
CNT_W, ADDR_W+1, width of load_count (must represent DEPTH itself)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  single-cycle pulse: begin new image load at address 0
load_valid  in  1  load_data/load_last valid
load_data  in  DATA_W  instruction word to store
load_last  in  1  marks final word of image
load_ready  out  1  block accepts a word this cycle
load_busy  out  1  state is LOAD
load_done  out  1  image complete; sticky until next load_start or reset
load_err  out  1  overflow: DEPTH words accepted without load_last; sticky
load_count  out  CNT_W  number of words accepted in current/last load
proc_hold  out  1  pipeline must stall; 0 only in DONE
fetch_en  in  1  fetch request
fetch_addr  in  ADDR_W  word address of instruction
fetch_valid  out  1  fetch_data/fetch_data_next valid
fetch_data  out  DATA_W  mem[fetch_addr] from previous cycle's request
fetch_data_next  out  DATA_W  mem[(fetch_addr+1) mod DEPTH]
fetch_oob  out  1  requested fetch_addr >= load_count

Behaviour:
- States IDLE, LOAD, DONE, ERR. Reset -> IDLE; load_ready=0, load_busy=0, load_done=0, load_err=0, load_count=0, proc_hold=1, fetch_valid=0, fetch_data=0, fetch_data_next=0, fetch_oob=0. Memory contents not reset.
- IDLE/DONE/ERR + load_start -> LOAD next cycle; wr_ptr=0, load_count=0, load_done=0, load_err=0. load_start while in LOAD ignored.
- LOAD: load_ready=1 (combinational from state). Transfer = load_valid & load_ready: mem[wr_ptr]<=load_data, wr_ptr+=1, load_count+=1.
- Transfer with load_last -> DONE (load_done=1 next cycle), including at wr_ptr=DEPTH-1.
- Transfer at wr_ptr=DEPTH-1 without load_last -> ERR; word is written, load_count=DEPTH, load_err=1. ERR: load_ready=0, words refused.
- load_valid low in LOAD: no change, wait indefinitely.
- proc_hold = (state != DONE), registered with state.
- Fetch: when fetch_en & ~proc_hold, next cycle fetch_valid=1, fetch_data, fetch_data_next, fetch_oob updated. Otherwise fetch_valid=0; data outputs hold last values.
- Address DEPTH-1: fetch_data_next = mem[0] (wrap).
- fetch_oob = registered (fetch_addr >= load_count); data still returned.
- load_start and fetch_en same cycle in DONE: fetch served (fetch_valid=1 next cycle); proc_hold=1 from next cycle.
- Reset mid-load: immediate return to IDLE values; partially written words remain but proc_hold=1 until a full reload.
- No write/read collision: writes occur only while proc_hold=1.

Decomposition:
- imem_pkg: state encoding constants (IDLE=0, LOAD=1, DONE=2, ERR=3); DEPTH localparam derivation.
- Sub-module imem_ram: DATA_W x DEPTH, one synchronous write port, two synchronous read ports (addr, addr+1); no reset on array. Top holds FSM, counters, fetch registers.

Test Plan (ADDR_W=4, DATA_W=16):
- Reset, then load_start, stream 0x1111,0x2222,0x3333 (last on third) -> load_done=1, load_count=3, proc_hold=0; fetch addr 1 -> next cycle fetch_valid=1, data=0x2222, next=0x3333, oob=0.
- Load with load_valid toggling 1,0,0,1 (last) -> exactly 2 words stored, load_count=2, ready stays 1 during gaps.
- Stream 16 words 0x0000..0x000F, no last -> load_err=1, load_count=16, load_ready=0; 17th word refused; proc_hold=1; fetch_en gives fetch_valid=0.
- 16 words with last on 16th -> DONE, load_err=0; fetch addr 15 -> data=0x000F, next=0x0000; fetch addr 3 after 3-word load -> oob=1.
- Assert rst_n low after 2 of 5 words -> all outputs reset values; new load_start reloads from address 0 correctly.
- In DONE, load_start with fetch_en same cycle -> fetch_valid=1 next cycle, proc_hold=1, load_done=0, load_busy=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared state encoding and memory-size helper for the instruction-memory loader.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 20;

   function automatic int depth_f(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction store: one synchronous write port, paired synchronous reads of addr and addr+1.
// Array is not reset; only the read registers are, so fetch outputs start at zero.
module imem_ram
   import imem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata0_o,
   output logic [DATA_W-1:0] rdata1_o
);

   localparam int DEPTH = depth_f(ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic [ADDR_W-1:0] raddr_next;

   // Natural ADDR_W-bit overflow gives the wrap from DEPTH-1 back to 0.
   assign raddr_next = raddr_i + 1'b1;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (re_i) begin
         rdata0_q <= mem[raddr_i];
         rdata1_q <= mem[raddr_next];
      end
   end

   assign rdata0_o = rdata0_q;
   assign rdata1_o = rdata1_q;

endmodule

// File: rtl/imem_stream_loader.sv
// Instruction memory filled from a valid/ready word stream; holds the pipeline until an image
// is complete, then serves 1-cycle-latency two-word fetches.
module imem_stream_loader
   import imem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err,
   output logic [CNT_W-1:0]  load_count,
   output logic              proc_hold,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic [DATA_W-1:0] fetch_data_next,
   output logic              fetch_oob
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              hold_q, hold_d;
   logic              fvalid_q, fvalid_d;
   logic              foob_q, foob_d;
   logic              xfer;
   logic              fire;

   assign load_ready = (state_q == ST_LOAD);
   assign xfer       = load_valid & load_ready;
   assign fire       = fetch_en & ~hold_q;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      done_d   = done_q;
      err_d    = err_q;
      case (state_q)
         ST_LOAD: begin
            if (xfer) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + 1'b1;
               // load_last takes priority so an image exactly DEPTH words long completes.
               if (load_last) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (&wr_ptr_q) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: begin
            if (load_start) begin
               state_d  = ST_LOAD;
               wr_ptr_d = '0;
               count_d  = '0;
               done_d   = 1'b0;
               err_d    = 1'b0;
            end
         end
      endcase
      hold_d   = (state_d != ST_DONE);
      fvalid_d = fire;
      foob_d   = fire ? ({1'b0, fetch_addr} >= count_q) : foob_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         hold_q   <= 1'b1;
         fvalid_q <= 1'b0;
         foob_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         done_q   <= done_d;
         err_q    <= err_d;
         hold_q   <= hold_d;
         fvalid_q <= fvalid_d;
         foob_q   <= foob_d;
      end
   end

   imem_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (xfer),
      .waddr_i  (wr_ptr_q),
      .wdata_i  (load_data),
      .re_i     (fire),
      .raddr_i  (fetch_addr),
      .rdata0_o (fetch_data),
      .rdata1_o (fetch_data_next)
   );

   assign load_busy   = (state_q == ST_LOAD);
   assign load_done   = done_q;
   assign load_err    = err_q;
   assign load_count  = count_q;
   assign proc_hold   = hold_q;
   assign fetch_valid = fvalid_q;
   assign fetch_oob   = foob_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader at ADDR_W=4, DATA_W=16.
module tb_imem_stream_loader;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int CNT_W  = ADDR_W + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              load_start;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic              load_busy;
   logic              load_done;
   logic              load_err;
   logic [CNT_W-1:0]  load_count;
   logic              proc_hold;
   logic              fetch_en;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_data;
   logic [DATA_W-1:0] fetch_data_next;
   logic              fetch_oob;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   imem_stream_loader #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .load_start      (load_start),
      .load_valid      (load_valid),
      .load_data       (load_data),
      .load_last       (load_last),
      .load_ready      (load_ready),
      .load_busy       (load_busy),
      .load_done       (load_done),
      .load_err        (load_err),
      .load_count      (load_count),
      .proc_hold       (proc_hold),
      .fetch_en        (fetch_en),
      .fetch_addr      (fetch_addr),
      .fetch_valid     (fetch_valid),
      .fetch_data      (fetch_data),
      .fetch_data_next (fetch_data_next),
      .fetch_oob       (fetch_oob)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] a);
      fetch_en   = 1'b1;
      fetch_addr = a;
      tick();
      fetch_en   = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, 32'(load_ready), 32'd0);
      check({tag, "_busy"},  32'(load_busy),  32'd0);
      check({tag, "_done"},  32'(load_done),  32'd0);
      check({tag, "_err"},   32'(load_err),   32'd0);
      check({tag, "_count"}, 32'(load_count), 32'd0);
      check({tag, "_hold"},  32'(proc_hold),  32'd1);
      check({tag, "_fvld"},  32'(fetch_valid), 32'd0);
      check({tag, "_fdat"},  32'(fetch_data), 32'd0);
      check({tag, "_fnxt"},  32'(fetch_data_next), 32'd0);
      check({tag, "_oob"},   32'(fetch_oob),  32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      fetch_en   = 1'b0;
      fetch_addr = '0;
      repeat (3) tick();
      check_reset_values("rst");
      rst_n = 1'b1;
      tick();

      // Basic three-word image, then fetches.
      start_load();
      check("t1_busy", 32'(load_busy), 32'd1);
      check("t1_ready", 32'(load_ready), 32'd1);
      send(16'h1111, 1'b0);
      send(16'h2222, 1'b0);
      send(16'h3333, 1'b1);
      check("t1_done", 32'(load_done), 32'd1);
      check("t1_count", 32'(load_count), 32'd3);
      check("t1_hold", 32'(proc_hold), 32'd0);
      check("t1_busy_off", 32'(load_busy), 32'd0);
      fetch(4'd1);
      check("t1_fvld", 32'(fetch_valid), 32'd1);
      check("t1_fdat", 32'(fetch_data), 32'h2222);
      check("t1_fnxt", 32'(fetch_data_next), 32'h3333);
      check("t1_oob", 32'(fetch_oob), 32'd0);
      tick();
      check("t1_fvld_idle", 32'(fetch_valid), 32'd0);
      check("t1_fdat_hold", 32'(fetch_data), 32'h2222);
      fetch(4'd3);
      check("t1_oob3", 32'(fetch_oob), 32'd1);
      check("t1_fvld3", 32'(fetch_valid), 32'd1);

      // Gapped stream: valid 1,0,0,1(last).
      start_load();
      check("t2_count_clr", 32'(load_count), 32'd0);
      check("t2_done_clr", 32'(load_done), 32'd0);
      send(16'hAAAA, 1'b0);
      tick();
      check("t2_ready_gap1", 32'(load_ready), 32'd1);
      check("t2_count_gap1", 32'(load_count), 32'd1);
      tick();
      check("t2_ready_gap2", 32'(load_ready), 32'd1);
      send(16'hBBBB, 1'b1);
      check("t2_count", 32'(load_count), 32'd2);
      check("t2_done", 32'(load_done), 32'd1);
      fetch(4'd0);
      check("t2_fdat", 32'(fetch_data), 32'hAAAA);
      check("t2_fnxt", 32'(fetch_data_next), 32'hBBBB);
      check("t2_oob0", 32'(fetch_oob), 32'd0);
      fetch(4'd2);
      check("t2_fdat2", 32'(fetch_data), 32'h3333);
      check("t2_oob2", 32'(fetch_oob), 32'd1);

      // Overflow: 16 words with no last.
      start_load();
      for (int i = 0; i < 16; i++) send(16'(i), 1'b0);
      check("t3_err", 32'(load_err), 32'd1);
      check("t3_count", 32'(load_count), 32'd16);
      check("t3_ready", 32'(load_ready), 32'd0);
      check("t3_done", 32'(load_done), 32'd0);
      check("t3_hold", 32'(proc_hold), 32'd1);
      send(16'hDEAD, 1'b0);
      check("t3_count17", 32'(load_count), 32'd16);
      check("t3_err_sticky", 32'(load_err), 32'd1);
      fetch(4'd0);
      check("t3_fvld", 32'(fetch_valid), 32'd0);

      // Full-depth image with last on the sixteenth word.
      start_load();
      check("t4_err_clr", 32'(load_err), 32'd0);
      for (int i = 0; i < 16; i++) send(16'(i), (i == 15));
      check("t4_done", 32'(load_done), 32'd1);
      check("t4_err", 32'(load_err), 32'd0);
      check("t4_count", 32'(load_count), 32'd16);
      fetch(4'd15);
      check("t4_fdat", 32'(fetch_data), 32'h000F);
      check("t4_fnxt_wrap", 32'(fetch_data_next), 32'h0000);
      check("t4_oob", 32'(fetch_oob), 32'd0);

      // Reset in the middle of a five-word load, then reload.
      start_load();
      send(16'h5555, 1'b0);
      send(16'h6666, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_values("t5_rst");
      tick();
      rst_n = 1'b1;
      tick();
      start_load();
      send(16'h7777, 1'b0);
      send(16'h8888, 1'b0);
      send(16'h9999, 1'b1);
      check("t5_count", 32'(load_count), 32'd3);
      check("t5_hold", 32'(proc_hold), 32'd0);
      fetch(4'd0);
      check("t5_fdat", 32'(fetch_data), 32'h7777);
      check("t5_fnxt", 32'(fetch_data_next), 32'h8888);

      // load_start and fetch_en together while DONE.
      load_start = 1'b1;
      fetch_en   = 1'b1;
      fetch_addr = 4'd2;
      tick();
      load_start = 1'b0;
      fetch_en   = 1'b0;
      check("t6_fvld", 32'(fetch_valid), 32'd1);
      check("t6_fdat", 32'(fetch_data), 32'h9999);
      check("t6_fnxt", 32'(fetch_data_next), 32'h0003);
      check("t6_oob", 32'(fetch_oob), 32'd0);
      check("t6_hold", 32'(proc_hold), 32'd1);
      check("t6_done", 32'(load_done), 32'd0);
      check("t6_busy", 32'(load_busy), 32'd1);
      check("t6_count", 32'(load_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
